fire_pool: RTL and testbench
============================

# fire_pool

Multi-projectile enemy-fire controller for the scrolling level. Once the background scroll position passes a trigger step, it spawns up to `N_FIRE` fire sprites at a home point, steers each one toward Mario every game tick, and compensates for background scroll. It retires sprites on lifetime expiry, off-screen exit or (optionally) contact with Mario. Per pixel, it produces the sprite-ROM read address and an `is_fire` flag for the colour mapper.

## Interface
Parameters:
- `N_FIRE`, 4: number of fire slots (1–8)
- `TICK_DIV`, 3_000_000: Clk cycles per game tick
- `TRIGGER_STEP`, 292: arming threshold; block arms when `BG_step` > value
- `HOME_X` / `HOME_Y`, 340 / 320: spawn position
- `STEP`, 2: chase step per tick, both axes
- `SCROLL_COMP`, 8: X compensation per tick for scroll keys
- `SPAWN_GAP`, 8: ticks between spawns
- `LIFETIME`, 64: ticks a slot lives
- `SPR_W` / `SPR_H`, 48 / 16: on-screen size (2× scaled)
- `ROM_COL0` / `ROM_ROW0` / `ROM_PITCH`, 112 / 99 / 188: sprite-sheet origin and row pitch
- `FRAME_OFS`, 24: column offset of the second animation frame

Ports:
- `Clk` in 1: system clock
- `Reset` in 1: reset, asynchronous, active-high
- `BG_step` in 9: background scroll position
- `keycode` in 32: four USB keycodes; 0x04 = left, 0x07 = right
- `MarioX`, `MarioY`, `MarioS_X`, `MarioS_Y` in 10 each: Mario box
- `DrawX`, `DrawY` in 10 each: VGA pixel coordinate
- `FireReadAdd` out 19: sprite-ROM address, registered
- `is_fire` out 1: current pixel belongs to an active fire, registered
- `active` out N_FIRE: slot-occupied flags
- `hit` out 1: one-Clk pulse on Mario contact

## Operation
- **Tick generator:** counter 0..`TICK_DIV`-1. `tick` asserts for one Clk when the counter wraps. There is no derived clock; all state is on Clk, enabled by `tick`.
- **Global FSM `ARMED` → `RUNNING`:** transition on the first tick where `BG_step` > `TRIGGER_STEP`. `RUNNING` is sticky until Reset, even if `BG_step` later drops.
- **Spawn (`RUNNING`, tick, `gap_cnt` = 0, a free slot exists):**
  - lowest-index free slot takes position (`HOME_X`, `HOME_Y`), `life` = `LIFETIME`, `frame` = 0
  - `gap_cnt` reloads to `SPAWN_GAP`-1
  - otherwise `gap_cnt` decrements, saturating at 0
  - when all slots are busy, `gap_cnt` holds at 0 and the spawn happens on the first tick a slot is free
- **Per active slot, each tick:**
  - dx = −`STEP` if `MarioX`+`MarioS_X` ≤ X−`STEP`, else 0
  - dx += `SCROLL_COMP` if left only; −`SCROLL_COMP` if right only; 0 if both or neither
  - dy = +`STEP` if `MarioY` > Y+`STEP`; −`STEP` if `MarioY` < Y+`STEP`; else 0
  - new position = old + motion, applied in the same tick (no one-tick-late motion)
  - `frame` toggles; `life` decrements
- **Retire** (slot freed, `active` bit cleared) when any of:
  - `life` reaches 0
  - 11-bit signed X+dx < 0 or > 639
  - Y+dy < 0 or > 479
  - contact (see Configuration)
- **Same tick:** retire is evaluated before spawn. The spawn picks among slots free at the start of the tick, so a slot never retires and respawns in one tick.
- **Render:**
  - slot hit when X ≤ `DrawX` < X+`SPR_W` and Y ≤ `DrawY` < Y+`SPR_H`
  - lowest-index hit slot wins
  - address = (`DrawX`−X)/2 + `ROM_COL0` + `frame`·`FRAME_OFS` + ((`DrawY`−Y)/2 + `ROM_ROW0`)·`ROM_PITCH`
  - no hit: address 0, `is_fire` 0
- **Arithmetic:** positions are 10-bit unsigned. Motion is 10-bit two's complement, added modulo 1024 except where the bounds check uses the 11-bit signed sum.

## Timing
- **Reset values:** `FireReadAdd` 0, `is_fire` 0, `active` 0, `hit` 0; FSM `ARMED`; tick counter 0, `gap_cnt` 0.
- **Reset mid-operation:** clears everything immediately, asynchronously.
- **Render latency:** `is_fire` and `FireReadAdd` lag `DrawX`/`DrawY` by 1 Clk. The ROM adds its own cycle; the colour mapper aligns.
- **State update:** `active` and positions change in the Clk cycle after `tick`.
- **`hit`:** asserts for exactly that cycle.

## Configuration
- **`FIRE_COLLISION_EN` defined:**
  - per-slot box-overlap test against the Mario box on each tick
  - overlapping slot retires and `hit` pulses (one pulse even if several slots overlap)
- **Not defined:** `hit` tied 0; slots retire only on lifetime or off-screen.

## Structure
- **Package `fire_pkg`:**
  - slot struct (x, y, life, frame, valid)
  - screen bounds 640/480
  - keycode constants 0x04 and 0x07
- **Sub-module `fire_slot`:** one slot's registers, motion and retire logic, instantiated `N_FIRE` times by generate. Spawn arbitration, tick, FSM and render mux stay in the top.

## Test plan
- **Arm threshold:** `TICK_DIV`=4; `BG_step`=292 for 10 ticks → `active`=0. `BG_step`=293 → next tick state `RUNNING`, slot 0 active at (340,320).
- **Spawn gap and fill:** `SPAWN_GAP`=2 → slots 0,1,2,3 spawn on ticks 1,3,5,7. No fifth spawn; `gap_cnt` holds at 0.
- **Chase:** slot at (340,320); Mario (100,400), size 16×16, no keys → next tick (338,322). Left key only → (346,322). Both keys → (338,322).
- **Off-screen and lifetime:**
  - X=1 with dx=−2 → slot retires that tick
  - `LIFETIME`=3 → slot freed after 3 ticks, freed slot reused on the next spawn
- **Render:** slot 0 at (340,320), frame 0; `DrawX`=342, `DrawY`=322 → one Clk later `is_fire`=1, `FireReadAdd`=113+100·188=18913. Two overlapping slots → lower index's address.
- **Collision (macro on):** place Mario overlapping slot 1 → `hit` high exactly one Clk; `active[1]` clears. Assert Reset mid-run → all outputs 0 immediately.

Source files
------------

// File: rtl/fire_pkg.sv
// fire_pkg: shared types and constants for the fire_pool enemy-fire block.
//   slot_t        - per-slot state (position, remaining life, animation frame, valid)
//   fire_state_e  - global controller state (ARMED / RUNNING)
//   SCREEN_W/H    - visible area bounds used by the off-screen retire test
//   KEY_LEFT/RIGHT- USB keycodes that scroll the background
//   key_down()    - true when any of the four keycode bytes equals a given key
package fire_pkg;

    localparam int SCREEN_W = 640;
    localparam int SCREEN_H = 480;

    localparam logic [7:0] KEY_LEFT  = 8'h04;
    localparam logic [7:0] KEY_RIGHT = 8'h07;

    localparam int LIFE_W = 8;

    typedef enum logic {
        ARMED   = 1'b0,
        RUNNING = 1'b1
    } fire_state_e;

    typedef struct packed {
        logic [9:0]        x;
        logic [9:0]        y;
        logic [LIFE_W-1:0] life;
        logic              frame;
        logic              valid;
    } slot_t;

    function automatic logic key_down(input logic [31:0] codes, input logic [7:0] key);
        key_down = (codes[7:0]   == key) || (codes[15:8]  == key) ||
                   (codes[23:16] == key) || (codes[31:24] == key);
    endfunction

endpackage

// File: rtl/fire_slot.sv
// fire_slot: registers, chase motion and retire logic for one fire sprite.
// Ports:
//   Clk, Reset        - clock, asynchronous active-high reset
//   tick_i            - one-Clk game-tick enable
//   spawn_i           - load this (free) slot at the home point on this tick
//   left_i / right_i  - scroll keys currently held
//   mario_x_i, mario_y_i, mario_sx_i - Mario box position and width
//   contact_i         - slot overlaps Mario this tick (always 0 without collision)
//   slot_o            - current slot state
module fire_slot
    import fire_pkg::*;
#(
    parameter int HOME_X      = 340,
    parameter int HOME_Y      = 320,
    parameter int STEP        = 2,
    parameter int SCROLL_COMP = 8,
    parameter int LIFETIME    = 64
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       tick_i,
    input  logic       spawn_i,
    input  logic       left_i,
    input  logic       right_i,
    input  logic [9:0] mario_x_i,
    input  logic [9:0] mario_y_i,
    input  logic [9:0] mario_sx_i,
    input  logic       contact_i,
    output slot_t      slot_o
);

    slot_t              slot_q, slot_d;
    logic signed [11:0] mario_right_s;
    logic signed [11:0] x_less_step_s;
    logic        [10:0] y_plus_step;
    logic signed [10:0] dx, dy;
    logic signed [10:0] nx, ny;
    logic               retire;

    always_comb begin
        // Chase on X only ever steps left: the fire closes in from the right.
        mario_right_s = $signed({2'b00, mario_x_i}) + $signed({2'b00, mario_sx_i});
        x_less_step_s = $signed({2'b00, slot_q.x}) - $signed(12'(STEP));
        dx = '0;
        if (mario_right_s <= x_less_step_s)
            dx = -$signed(11'(STEP));
        // Pressing both scroll keys cancels out.
        if (left_i && !right_i)
            dx = dx + $signed(11'(SCROLL_COMP));
        else if (right_i && !left_i)
            dx = dx - $signed(11'(SCROLL_COMP));

        y_plus_step = {1'b0, slot_q.y} + 11'(STEP);
        dy = '0;
        if ({1'b0, mario_y_i} > y_plus_step)
            dy = $signed(11'(STEP));
        else if ({1'b0, mario_y_i} < y_plus_step)
            dy = -$signed(11'(STEP));

        nx = $signed({1'b0, slot_q.x}) + dx;
        ny = $signed({1'b0, slot_q.y}) + dy;

        retire = (slot_q.life == LIFE_W'(1))
              || (nx < 0) || (nx > $signed(11'(SCREEN_W - 1)))
              || (ny < 0) || (ny > $signed(11'(SCREEN_H - 1)))
              || contact_i;

        slot_d = slot_q;
        if (tick_i) begin
            if (slot_q.valid) begin
                if (retire) begin
                    slot_d.valid = 1'b0;
                end else begin
                    slot_d.x     = nx[9:0];
                    slot_d.y     = ny[9:0];
                    slot_d.frame = ~slot_q.frame;
                    slot_d.life  = slot_q.life - LIFE_W'(1);
                end
            end else if (spawn_i) begin
                slot_d.valid = 1'b1;
                slot_d.x     = 10'(HOME_X);
                slot_d.y     = 10'(HOME_Y);
                slot_d.life  = LIFE_W'(LIFETIME);
                slot_d.frame = 1'b0;
            end
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) slot_q <= '0;
        else       slot_q <= slot_d;
    end

    assign slot_o = slot_q;

endmodule

// File: rtl/fire_pool.sv
// fire_pool: multi-projectile enemy-fire controller.
// Arms once BG_step passes TRIGGER_STEP, then spawns fire sprites at the
// home point every SPAWN_GAP ticks, chases Mario, and renders them.
// Optional feature macro: FIRE_COLLISION_EN (Mario contact retires a slot
// and pulses hit); without it hit is tied 0.
// Ports:
//   Clk, Reset          - clock, asynchronous active-high reset
//   BG_step             - background scroll position
//   keycode             - four USB keycodes (0x04 left, 0x07 right)
//   MarioX/Y, MarioS_X/Y- Mario box
//   DrawX, DrawY        - current VGA pixel
//   FireReadAdd         - sprite-ROM address (registered, 1 Clk after DrawX/Y)
//   is_fire             - pixel belongs to an active fire (registered)
//   active              - per-slot occupied flags
//   hit                 - one-Clk pulse on Mario contact
module fire_pool
    import fire_pkg::*;
#(
    parameter int N_FIRE       = 4,
    parameter int TICK_DIV     = 3_000_000,
    parameter int TRIGGER_STEP = 292,
    parameter int HOME_X       = 340,
    parameter int HOME_Y       = 320,
    parameter int STEP         = 2,
    parameter int SCROLL_COMP  = 8,
    parameter int SPAWN_GAP    = 8,
    parameter int LIFETIME     = 64,
    parameter int SPR_W        = 48,
    parameter int SPR_H        = 16,
    parameter int ROM_COL0     = 112,
    parameter int ROM_ROW0     = 99,
    parameter int ROM_PITCH    = 188,
    parameter int FRAME_OFS    = 24
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic [8:0]        BG_step,
    input  logic [31:0]       keycode,
    input  logic [9:0]        MarioX,
    input  logic [9:0]        MarioY,
    input  logic [9:0]        MarioS_X,
    input  logic [9:0]        MarioS_Y,
    input  logic [9:0]        DrawX,
    input  logic [9:0]        DrawY,
    output logic [18:0]       FireReadAdd,
    output logic              is_fire,
    output logic [N_FIRE-1:0] active,
    output logic              hit
);

    localparam int TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int GAP_W  = 8;

    logic [TICK_W-1:0] tick_cnt_q;
    logic              tick;
    fire_state_e       state_q;
    logic              running;
    logic [GAP_W-1:0]  gap_q, gap_d;
    logic              any_free;
    logic [N_FIRE-1:0] spawn_vec;
    logic [N_FIRE-1:0] contact_vec;
    logic [N_FIRE-1:0] pix_hit;
    logic [18:0]       pix_addr [N_FIRE];
    slot_t             slots [N_FIRE];
    logic              key_left, key_right;
    logic              is_fire_q, is_fire_d;
    logic [18:0]       addr_q, addr_d;

    assign key_left  = key_down(keycode, KEY_LEFT);
    assign key_right = key_down(keycode, KEY_RIGHT);

    // Game tick: single-cycle enable when the divider wraps.
    assign tick = (tick_cnt_q == TICK_W'(TICK_DIV - 1));

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset)     tick_cnt_q <= '0;
        else if (tick) tick_cnt_q <= '0;
        else           tick_cnt_q <= tick_cnt_q + TICK_W'(1);
    end

    // RUNNING is sticky: a later drop of BG_step does not disarm.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q <= ARMED;
        end else begin
            case (state_q)
                ARMED:   if (tick && (BG_step > 9'(TRIGGER_STEP))) state_q <= RUNNING;
                RUNNING: state_q <= RUNNING;
            endcase
        end
    end

    assign running = (state_q == RUNNING);

    // Free slots are judged on start-of-tick state, so a slot retiring this
    // tick cannot be respawned until the next one.
    always_comb begin
        spawn_vec = '0;
        any_free  = 1'b0;
        for (int i = 0; i < N_FIRE; i++) begin
            if (!slots[i].valid && !any_free) begin
                any_free     = 1'b1;
                spawn_vec[i] = tick && running && (gap_q == '0);
            end
        end
    end

    // gap_cnt stays at 0 while the pool is full so the spawn fires on the
    // first tick a slot frees up.
    always_comb begin
        gap_d = gap_q;
        if (tick && running) begin
            if (gap_q != '0)   gap_d = gap_q - GAP_W'(1);
            else if (any_free) gap_d = GAP_W'(SPAWN_GAP - 1);
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) gap_q <= '0;
        else       gap_q <= gap_d;
    end

    for (genvar g = 0; g < N_FIRE; g++) begin : g_slot
        logic [8:0] rx_half, ry_half;

        fire_slot #(
            .HOME_X      (HOME_X),
            .HOME_Y      (HOME_Y),
            .STEP        (STEP),
            .SCROLL_COMP (SCROLL_COMP),
            .LIFETIME    (LIFETIME)
        ) u_slot (
            .Clk        (Clk),
            .Reset      (Reset),
            .tick_i     (tick),
            .spawn_i    (spawn_vec[g]),
            .left_i     (key_left),
            .right_i    (key_right),
            .mario_x_i  (MarioX),
            .mario_y_i  (MarioY),
            .mario_sx_i (MarioS_X),
            .contact_i  (contact_vec[g]),
            .slot_o     (slots[g])
        );

`ifdef FIRE_COLLISION_EN
        assign contact_vec[g] = slots[g].valid
            && ({1'b0, slots[g].x} < {1'b0, MarioX} + {1'b0, MarioS_X})
            && ({1'b0, MarioX} < {1'b0, slots[g].x} + 11'(SPR_W))
            && ({1'b0, slots[g].y} < {1'b0, MarioY} + {1'b0, MarioS_Y})
            && ({1'b0, MarioY} < {1'b0, slots[g].y} + 11'(SPR_H));
`else
        assign contact_vec[g] = 1'b0;
`endif

        assign active[g] = slots[g].valid;

        assign pix_hit[g] = slots[g].valid
            && (DrawX >= slots[g].x) && ({1'b0, DrawX} < {1'b0, slots[g].x} + 11'(SPR_W))
            && (DrawY >= slots[g].y) && ({1'b0, DrawY} < {1'b0, slots[g].y} + 11'(SPR_H));

        // Sprite is drawn 2x scaled, so the ROM offset is half the screen offset.
        assign rx_half = 9'((DrawX - slots[g].x) >> 1);
        assign ry_half = 9'((DrawY - slots[g].y) >> 1);

        assign pix_addr[g] = 19'(rx_half) + 19'(ROM_COL0)
                           + (slots[g].frame ? 19'(FRAME_OFS) : 19'd0)
                           + (19'(ry_half) + 19'(ROM_ROW0)) * 19'(ROM_PITCH);
    end

`ifdef FIRE_COLLISION_EN
    logic hit_q;
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) hit_q <= 1'b0;
        else       hit_q <= tick && running && (|contact_vec);
    end
    assign hit = hit_q;
`else
    logic unused_mario_sy;
    assign unused_mario_sy = ^MarioS_Y;
    assign hit = 1'b0;
`endif

    // Descending scan: the last assignment is the lowest-index hit slot.
    always_comb begin
        is_fire_d = 1'b0;
        addr_d    = '0;
        for (int i = N_FIRE - 1; i >= 0; i--) begin
            if (pix_hit[i]) begin
                is_fire_d = 1'b1;
                addr_d    = pix_addr[i];
            end
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            is_fire_q <= 1'b0;
            addr_q    <= '0;
        end else begin
            is_fire_q <= is_fire_d;
            addr_q    <= addr_d;
        end
    end

    assign is_fire     = is_fire_q;
    assign FireReadAdd = addr_q;

endmodule

// File: tb/tb_fire_pool.sv
// tb_fire_pool: directed bench for fire_pool. Two instances share stimulus:
// u_dut with the default lifetime and u_life with a 3-tick lifetime.
module tb_fire_pool;

    localparam int TD = 16;

    logic        Clk = 1'b0;
    logic        Reset;
    logic [8:0]  BG_step;
    logic [31:0] keycode;
    logic [9:0]  MarioX, MarioY, MarioS_X, MarioS_Y;
    logic [9:0]  DrawX, DrawY;

    logic [18:0] addr;
    logic        fire;
    logic [3:0]  act;
    logic        hit;
    logic [18:0] l_addr;
    logic        l_fire;
    logic [3:0]  l_act;
    logic        l_hit;

    int n_total = 0;
    int n_bad   = 0;
    int cyc;

    logic [3:0] exp_q[$];

    fire_pool #(.N_FIRE(4), .TICK_DIV(TD), .SPAWN_GAP(2)) u_dut (
        .Clk(Clk), .Reset(Reset), .BG_step(BG_step), .keycode(keycode),
        .MarioX(MarioX), .MarioY(MarioY), .MarioS_X(MarioS_X), .MarioS_Y(MarioS_Y),
        .DrawX(DrawX), .DrawY(DrawY),
        .FireReadAdd(addr), .is_fire(fire), .active(act), .hit(hit)
    );

    fire_pool #(.N_FIRE(4), .TICK_DIV(TD), .SPAWN_GAP(2), .LIFETIME(3)) u_life (
        .Clk(Clk), .Reset(Reset), .BG_step(BG_step), .keycode(keycode),
        .MarioX(MarioX), .MarioY(MarioY), .MarioS_X(MarioS_X), .MarioS_Y(MarioS_Y),
        .DrawX(DrawX), .DrawY(DrawY),
        .FireReadAdd(l_addr), .is_fire(l_fire), .active(l_act), .hit(l_hit)
    );

    // clock / reset bookkeeping
    always #5 Clk = ~Clk;

    always @(posedge Clk or posedge Reset) begin
        if (Reset) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: bench did not reach its summary");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    // Advance to #1 after the next clock edge on which a game tick is applied.
    task automatic next_tick();
        do begin
            @(posedge Clk);
            #1;
        end while (cyc % TD != 0);
    endtask

    task automatic probe(input logic [9:0] px, input logic [9:0] py);
        DrawX = px;
        DrawY = py;
        @(posedge Clk);
        #1;
    endtask

    task automatic set_mario(input logic [9:0] x, input logic [9:0] y,
                             input logic [9:0] sx, input logic [9:0] sy);
        MarioX = x; MarioY = y; MarioS_X = sx; MarioS_Y = sy;
    endtask

    task automatic chk_life(input string tag);
        chk(tag, l_act, exp_q.pop_front());
    endtask

    initial begin
        // Expected active flags of u_life after game ticks 1..9.
        exp_q = '{4'b0001, 4'b0001, 4'b0011, 4'b0010, 4'b0011,
                  4'b0001, 4'b0011, 4'b0010, 4'b0011};

        Reset = 1'b1; BG_step = 9'd292; keycode = 32'h0;
        set_mario(10'd100, 10'd400, 10'd16, 10'd16);
        DrawX = 10'd0; DrawY = 10'd0;
        repeat (3) @(posedge Clk);
        #1;
        chk("reset_addr", addr, 0);
        chk("reset_is_fire", fire, 0);
        chk("reset_active", act, 0);
        chk("reset_hit", hit, 0);

        @(negedge Clk);
        Reset = 1'b0;

        // Threshold is strict: BG_step equal to the trigger must not arm.
        for (int i = 0; i < 10; i++) next_tick();
        chk("no_arm_active", act, 0);
        chk("no_arm_life_active", l_act, 0);

        BG_step = 9'd293;
        next_tick();                                    // arming tick
        chk("arm_tick_active", act, 0);
        BG_step = 9'd0;                                 // RUNNING must stay sticky

        next_tick();                                    // tick 1: slot0 at (340,320)
        chk("t1_active", act, 4'b0001);
        chk_life("t1_life");
        probe(10'd340, 10'd320);
        chk("t1_home_fire", fire, 1);
        chk("t1_home_addr", addr, 18724);
        probe(10'd342, 10'd322);
        chk("t1_inner_addr", addr, 18913);
        probe(10'd339, 10'd320);
        chk("t1_left_edge_fire", fire, 0);
        chk("t1_left_edge_addr", addr, 0);

        next_tick();                                    // tick 2: slot0 -> (338,322), frame 1
        chk("t2_active", act, 4'b0001);
        chk_life("t2_life");
        probe(10'd338, 10'd322);
        chk("t2_chase_addr", addr, 18748);
        probe(10'd337, 10'd322);
        chk("t2_chase_edge_fire", fire, 0);

        keycode = 32'h0000_0004;                        // left only
        next_tick();                                    // tick 3: slot0 (344,324), slot1 spawns
        chk("t3_active", act, 4'b0011);
        chk_life("t3_life");
        probe(10'd344, 10'd324);
        chk("t3_overlap_low_wins", addr, 18724);
        probe(10'd342, 10'd322);
        chk("t3_slot1_addr", addr, 18913);

        keycode = 32'h0000_0704;                        // both keys
        next_tick();                                    // tick 4: slot0 (342,326), slot1 (338,322)
        chk("t4_active", act, 4'b0011);
        chk_life("t4_life");
        probe(10'd342, 10'd326);
        chk("t4_both_keys_slot0", addr, 18748);
        probe(10'd341, 10'd326);
        chk("t4_both_keys_slot1", addr, 19125);

        keycode = 32'h0000_0007;                        // right only
        next_tick();                                    // tick 5: slot0 (332,328), slot1 (328,324)
        chk("t5_active", act, 4'b0111);
        chk_life("t5_life");
        probe(10'd332, 10'd328);
        chk("t5_right_slot0", addr, 18724);
        probe(10'd331, 10'd328);
        chk("t5_right_slot1", addr, 19101);

        keycode = 32'h0;
        next_tick();
        chk("t6_active", act, 4'b0111);
        chk_life("t6_life");
        next_tick();
        chk("t7_active", act, 4'b1111);
        chk_life("t7_life");

        // Mario 1x1 box touching only slot1's top-left pixel at (324,328).
        set_mario(10'd324, 10'd328, 10'd1, 10'd1);
        next_tick();
`ifdef FIRE_COLLISION_EN
        chk("t8_hit_pulse", hit, 1);
        chk("t8_active", act, 4'b1101);
`else
        chk("t8_hit_pulse", hit, 0);
        chk("t8_active", act, 4'b1111);
`endif
        chk("t8_life_hit", l_hit, 0);
        chk_life("t8_life");
        @(posedge Clk);
        #1;
        chk("t8_hit_after", hit, 0);

        set_mario(10'd100, 10'd400, 10'd16, 10'd16);
        next_tick();
        chk("t9_active", act, 4'b1111);
        chk_life("t9_life");

        // Asynchronous reset in the middle of a cycle.
        probe(10'd340, 10'd326);
        chk("pre_reset_fire", fire, 1);
        #2;
        Reset = 1'b1;
        #1;
        chk("async_reset_addr", addr, 0);
        chk("async_reset_fire", fire, 0);
        chk("async_reset_active", act, 0);
        chk("async_reset_hit", hit, 0);
        chk("async_reset_life_active", l_act, 0);
        chk("async_reset_life_fire", l_fire, 0);
        chk("async_reset_life_addr", l_addr, 0);
        repeat (2) @(posedge Clk);
        @(negedge Clk);

        // Drive slots off the left edge: -10 per tick, Y held steady.
        BG_step = 9'd293;
        keycode = 32'h0000_0007;
        set_mario(10'd0, 10'd322, 10'd0, 10'd0);
        Reset = 1'b0;
        next_tick();                                    // arming tick
        next_tick();                                    // tick 1
        chk("p2_t1_active", act, 4'b0001);
        for (int k = 2; k <= 35; k++) next_tick();
        chk("p2_t35_active", act, 4'b1111);
        probe(10'd0, 10'd320);
        chk("p2_x0_fire", fire, 1);
        chk("p2_x0_addr", addr, 18724);
        next_tick();                                    // tick 36: slot0 leaves screen
        chk("p2_offscreen_retire", act, 4'b1110);
        next_tick();                                    // tick 37: freed slot reused at once
        chk("p2_refill", act, 4'b1111);
        next_tick();                                    // tick 38: slot1 leaves screen
        chk("p2_second_retire", act, 4'b1101);
        chk("p2_hit", hit, 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
